// File: rtl/spectrum_bar_scanner_if.sv
// spectrum_bar_scanner_if: FFT band-magnitude handoff (done pulse plus eight 16-bit magnitudes)
interface spectrum_bar_scanner_if;
    logic             done;
    logic [7:0][15:0] mag;
    modport master (output done, mag);
    modport slave  (input  done, mag);
endinterface

// File: rtl/spectrum_bar_scanner.sv
// spectrum_bar_scanner: log2 bar quantiser with peak-hold, atomic commit and 8x8 LED column scan
module spectrum_bar_scanner #(
    parameter int SCAN_DIV         = 50000,
    parameter int PEAK_HOLD_FRAMES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    spectrum_bar_scanner_if.slave fft,
    output logic [7:0]            col_sel,
    output logic [7:0]            row_data,
    output logic                  frame_latched,
    output logic                  overrun
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] QUANT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam int         CW     = $clog2(SCAN_DIV);

    logic [1:0]       state;
    logic [2:0]       band;
    logic [7:0][15:0] snap;
    logic [7:0][3:0]  peak;
    logic [7:0][7:0]  hold;
    logic [7:0][7:0]  work;
    logic [7:0][7:0]  disp;
    logic [CW-1:0]    cnt;
    logic [2:0]       column;
    logic [15:0]      mag;
    logic [3:0]       h;
    logic [3:0]       peak_nx;
    logic [7:0]       hold_nx;
    logic [7:0]       pat;

    // height, peak-hold step and column pattern for the band being quantised this cycle
    always_comb begin
        mag     = snap[band];
        h       = 4'd0;
        for (int i = 8; i < 16; i++) if (mag[i]) h = 4'(i - 7);
        peak_nx = peak[band];
        hold_nx = hold[band];
        if (h >= peak[band]) begin
            peak_nx = h;
            hold_nx = 8'(PEAK_HOLD_FRAMES);
        end else if (hold[band] != 8'd0) begin
            hold_nx = hold[band] - 8'd1;
        end else begin
            peak_nx = peak[band] - 4'd1;
        end
        pat = 8'((9'd1 << h) - 9'd1) | ((peak_nx != 4'd0) ? 8'(9'd1 << (peak_nx - 4'd1)) : 8'd0);
    end

    // frame FSM: snapshot, one band per QUANT cycle, then swap working patterns into the display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            band          <= 3'd0;
            snap          <= '0;
            peak          <= '0;
            hold          <= '0;
            work          <= '0;
            disp          <= '0;
            frame_latched <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_latched <= enable && state == COMMIT;
            overrun       <= fft.done && state != IDLE;
            if (!enable) begin
                state <= IDLE;
                band  <= 3'd0;
            end else if (state == IDLE && fft.done) begin
                snap  <= fft.mag;
                band  <= 3'd0;
                state <= QUANT;
            end else if (state == QUANT) begin
                peak[band] <= peak_nx;
                hold[band] <= hold_nx;
                work[band] <= pat;
                band       <= band + 3'd1;
                state      <= (band == 3'd7) ? COMMIT : QUANT;
            end else begin
                if (state == COMMIT) disp <= work;
                state <= IDLE;
            end
        end
    end

    // column scan: dwell SCAN_DIV cycles per column, blank and restart from column 0 when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            column   <= 3'd0;
            col_sel  <= 8'd0;
            row_data <= 8'd0;
        end else if (!enable) begin
            cnt      <= '0;
            column   <= 3'd0;
            col_sel  <= 8'd0;
            row_data <= 8'd0;
        end else begin
            cnt      <= (cnt == CW'(SCAN_DIV - 1)) ? '0 : cnt + 1'b1;
            column   <= (cnt == CW'(SCAN_DIV - 1)) ? column + 3'd1 : column;
            col_sel  <= 8'd1 << column;
            row_data <= disp[column];
        end
    end
endmodule
